vx_csr_bank: RTL

- Parametrised successor to the core CSR data store.
- Holds per-warp fcsr and per-warp scratch registers (NUM_SCRATCH of them), plus NUM_CTRS writable user event counters with an enable mask.
- Reads go through a registered valid/ready request/response pipe instead of a combinational read.
- Sits between the SFU CSR unit (reads/writes) and the FPU blocks (fflags accumulation, frm lookup), inside each core.

---
 rtl/vx_csr_bank_pkg.sv | 26 ++
 rtl/vx_csr_ctr.sv | 66 ++++++
 rtl/vx_csr_bank.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/vx_csr_bank_pkg.sv
// vx_csr_bank_pkg
//   Shared definitions for the per-core CSR data store: the CSR address
//   map, the fcsr field widths and the read-response record carried by the
//   registered read pipe.
package vx_csr_bank_pkg;

  localparam logic [11:0] CSR_FFLAGS       = 12'h001;
  localparam logic [11:0] CSR_FRM          = 12'h002;
  localparam logic [11:0] CSR_FCSR         = 12'h003;
  localparam logic [11:0] CSR_SCRATCH_BASE = 12'h7C0;
  localparam logic [11:0] CSR_CTR_EN       = 12'h7E0;
  localparam logic [11:0] CSR_CTR_BASE     = 12'hB03;
  localparam logic [11:0] CSR_CTR_H_BASE   = 12'hB83;

  localparam int FFLAGS_BITS = 5;
  localparam int FRM_BITS    = 3;

  // Sized for the widest supported XLEN; the bank keeps only the low XLEN bits.
  localparam int CSR_DATA_MAX = 64;

  typedef struct packed {
    logic [CSR_DATA_MAX-1:0] data;
    logic                    error;
  } csr_rsp_t;

endpackage

// File: rtl/vx_csr_ctr.sv
// vx_csr_ctr
//   One user event counter of CTR_BITS bits. Adds a zero-extended increment
//   each cycle while enabled, wrapping modulo 2^CTR_BITS. A write to either
//   half replaces that half and suppresses the increment for that cycle.
//
// Ports
//   clk, reset  clock, synchronous active-high reset (counter -> 0)
//   en_i        counter enable (bit of CTR_EN)
//   inc_i       increment for this cycle
//   wr_lo_i     write low half (XLEN=32) or whole counter (XLEN=64)
//   wr_hi_i     write high half, bits [CTR_BITS-1:32] (XLEN=32 only)
//   wr_data_i   write data
//   count_o     current counter value
module vx_csr_ctr #(
  parameter int XLEN     = 32,
  parameter int CTR_BITS = 44,
  parameter int INC_BITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en_i,
  input  logic [INC_BITS-1:0] inc_i,
  input  logic                wr_lo_i,
  input  logic                wr_hi_i,
  input  logic [XLEN-1:0]     wr_data_i,
  output logic [CTR_BITS-1:0] count_o
);

  logic [CTR_BITS-1:0] cnt_q;
  logic [CTR_BITS-1:0] cnt_d;
  logic [CTR_BITS-1:0] wrVal;

  // With a 32-bit data path each half is written separately and the other
  // half is preserved; a 64-bit data path writes the counter in one go.
  if (XLEN == 32) begin : g_x32
    always_comb begin
      wrVal = cnt_q;
      if (wr_lo_i) wrVal[31:0] = wr_data_i;
      if (wr_hi_i) wrVal[CTR_BITS-1:32] = wr_data_i[CTR_BITS-33:0];
    end
  end else begin : g_x64
    always_comb begin
      wrVal = wr_data_i[CTR_BITS-1:0];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo_i || wr_hi_i) begin
      cnt_d = wrVal;
    end else if (en_i) begin
      cnt_d = cnt_q + CTR_BITS'(inc_i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/vx_csr_bank.sv
// vx_csr_bank
//   Per-core CSR data store: per-warp fcsr and scratch registers, global
//   user event counters with an enable mask. Reads use a registered
//   valid/ready pipe sampling pre-update state; writes are never stalled.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   req_valid_i/req_ready_o, req_wid_i, req_addr_i   read request
//   rsp_valid_o/rsp_ready_i, rsp_data_o, rsp_error_o read response
//   wr_valid_i, wr_wid_i, wr_addr_i, wr_data_i       write strobe
//   wr_error_o          one-cycle pulse after an unmapped write
//   fpu_valid_i, fpu_wid_i, fpu_fflags_i             fflags accumulation
//   fpu_read_wid_i, fpu_read_frm_o                   combinational frm lookup
//   ctr_inc_i           per-counter increments this cycle
module vx_csr_bank
  import vx_csr_bank_pkg::*;
#(
  parameter  int XLEN          = 32,
  parameter  int NUM_WARPS     = 4,
  parameter  int NUM_FPU_PORTS = 2,
  parameter  int NUM_SCRATCH   = 2,
  parameter  int NUM_CTRS      = 8,
  parameter  int CTR_BITS      = 44,
  parameter  int INC_BITS      = 4,
  localparam int WID_W         = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       req_valid_i,
  output logic                                       req_ready_o,
  input  logic [WID_W-1:0]                           req_wid_i,
  input  logic [11:0]                                req_addr_i,
  output logic                                       rsp_valid_o,
  input  logic                                       rsp_ready_i,
  output logic [XLEN-1:0]                            rsp_data_o,
  output logic                                       rsp_error_o,
  input  logic                                       wr_valid_i,
  input  logic [WID_W-1:0]                           wr_wid_i,
  input  logic [11:0]                                wr_addr_i,
  input  logic [XLEN-1:0]                            wr_data_i,
  output logic                                       wr_error_o,
  input  logic [NUM_FPU_PORTS-1:0]                   fpu_valid_i,
  input  logic [NUM_FPU_PORTS-1:0][WID_W-1:0]        fpu_wid_i,
  input  logic [NUM_FPU_PORTS-1:0][FFLAGS_BITS-1:0]  fpu_fflags_i,
  input  logic [NUM_FPU_PORTS-1:0][WID_W-1:0]        fpu_read_wid_i,
  output logic [NUM_FPU_PORTS-1:0][FRM_BITS-1:0]     fpu_read_frm_o,
  input  logic [NUM_CTRS-1:0][INC_BITS-1:0]          ctr_inc_i
);

  localparam int FCSR_BITS = FFLAGS_BITS + FRM_BITS;

  logic [FCSR_BITS-1:0] fcsr_q    [NUM_WARPS];
  logic [FCSR_BITS-1:0] fcsr_d    [NUM_WARPS];
  logic [XLEN-1:0]      scratch_q [NUM_WARPS][NUM_SCRATCH];
  logic [NUM_CTRS-1:0]  ctrEn_q;
  logic                 wrError_q;
  logic                 rspValid_q;
  csr_rsp_t             rsp_q;

  logic [CTR_BITS-1:0]  ctrVal [NUM_CTRS];
  csr_rsp_t             rdRsp;
  logic                 reqAccept;

  logic                 wrFflags;
  logic                 wrFrm;
  logic                 wrFcsr;
  logic                 wrCtrEn;
  logic                 wrHit;
  logic [NUM_SCRATCH-1:0] wrScratch;
  logic [NUM_CTRS-1:0]  wrCtrLo;
  logic [NUM_CTRS-1:0]  wrCtrHi;

  // Read decode from current (pre-update) state; anything not matched
  // keeps error set with zero data.
  always_comb begin
    rdRsp       = '0;
    rdRsp.error = 1'b1;
    if (req_addr_i == CSR_FFLAGS) begin
      rdRsp.data  = CSR_DATA_MAX'(fcsr_q[req_wid_i][FFLAGS_BITS-1:0]);
      rdRsp.error = 1'b0;
    end
    if (req_addr_i == CSR_FRM) begin
      rdRsp.data  = CSR_DATA_MAX'(fcsr_q[req_wid_i][FCSR_BITS-1:FFLAGS_BITS]);
      rdRsp.error = 1'b0;
    end
    if (req_addr_i == CSR_FCSR) begin
      rdRsp.data  = CSR_DATA_MAX'(fcsr_q[req_wid_i]);
      rdRsp.error = 1'b0;
    end
    for (int s = 0; s < NUM_SCRATCH; s++) begin
      if (req_addr_i == CSR_SCRATCH_BASE + 12'(s)) begin
        rdRsp.data  = CSR_DATA_MAX'(scratch_q[req_wid_i][s]);
        rdRsp.error = 1'b0;
      end
    end
    if (req_addr_i == CSR_CTR_EN) begin
      rdRsp.data  = CSR_DATA_MAX'(ctrEn_q);
      rdRsp.error = 1'b0;
    end
    for (int i = 0; i < NUM_CTRS; i++) begin
      if (req_addr_i == CSR_CTR_BASE + 12'(i)) begin
        rdRsp.data  = (XLEN == 32) ? CSR_DATA_MAX'(ctrVal[i][31:0])
                                   : CSR_DATA_MAX'(ctrVal[i]);
        rdRsp.error = 1'b0;
      end
      if ((XLEN == 32) && (req_addr_i == CSR_CTR_H_BASE + 12'(i))) begin
        rdRsp.data  = CSR_DATA_MAX'(ctrVal[i][CTR_BITS-1:32]);
        rdRsp.error = 1'b0;
      end
    end
  end

  // Write decode; wrHit low on a valid write flags an unmapped address.
  always_comb begin
    wrFflags  = 1'b0;
    wrFrm     = 1'b0;
    wrFcsr    = 1'b0;
    wrCtrEn   = 1'b0;
    wrScratch = '0;
    wrCtrLo   = '0;
    wrCtrHi   = '0;
    if (wr_valid_i) begin
      wrFflags = (wr_addr_i == CSR_FFLAGS);
      wrFrm    = (wr_addr_i == CSR_FRM);
      wrFcsr   = (wr_addr_i == CSR_FCSR);
      wrCtrEn  = (wr_addr_i == CSR_CTR_EN);
      for (int s = 0; s < NUM_SCRATCH; s++) begin
        wrScratch[s] = (wr_addr_i == CSR_SCRATCH_BASE + 12'(s));
      end
      for (int i = 0; i < NUM_CTRS; i++) begin
        wrCtrLo[i] = (wr_addr_i == CSR_CTR_BASE + 12'(i));
        wrCtrHi[i] = (XLEN == 32) && (wr_addr_i == CSR_CTR_H_BASE + 12'(i));
      end
    end
    wrHit = wrFflags | wrFrm | wrFcsr | wrCtrEn | (|wrScratch) |
            (|wrCtrLo) | (|wrCtrHi);
  end

  // FPU flags are ORed in after any CSR write so a same-cycle software
  // write to fflags never drops flags raised by the FPUs.
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      logic [FFLAGS_BITS-1:0] flagsOr;
      flagsOr   = '0;
      fcsr_d[w] = fcsr_q[w];
      for (int p = 0; p < NUM_FPU_PORTS; p++) begin
        if (fpu_valid_i[p] && (fpu_wid_i[p] == WID_W'(w))) begin
          flagsOr = flagsOr | fpu_fflags_i[p];
        end
      end
      if (wr_wid_i == WID_W'(w)) begin
        if (wrFflags) fcsr_d[w][FFLAGS_BITS-1:0] = wr_data_i[FFLAGS_BITS-1:0];
        if (wrFrm)    fcsr_d[w][FCSR_BITS-1:FFLAGS_BITS] = wr_data_i[FRM_BITS-1:0];
        if (wrFcsr)   fcsr_d[w] = wr_data_i[FCSR_BITS-1:0];
      end
      fcsr_d[w][FFLAGS_BITS-1:0] = fcsr_d[w][FFLAGS_BITS-1:0] | flagsOr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        fcsr_q[w] <= '0;
        for (int s = 0; s < NUM_SCRATCH; s++) begin
          scratch_q[w][s] <= '0;
        end
      end
      ctrEn_q   <= '0;
      wrError_q <= 1'b0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        fcsr_q[w] <= fcsr_d[w];
      end
      for (int s = 0; s < NUM_SCRATCH; s++) begin
        if (wrScratch[s]) scratch_q[wr_wid_i][s] <= wr_data_i;
      end
      if (wrCtrEn) ctrEn_q <= wr_data_i[NUM_CTRS-1:0];
      wrError_q <= wr_valid_i & ~wrHit;
    end
  end

  // Single-entry response register: a new request is taken whenever the
  // slot is empty or being drained this cycle.
  assign req_ready_o = ~rspValid_q | rsp_ready_i;
  assign reqAccept   = req_valid_i & req_ready_o;

  always_ff @(posedge clk) begin
    if (reset) begin
      rspValid_q <= 1'b0;
      rsp_q      <= '0;
    end else if (reqAccept) begin
      rspValid_q <= 1'b1;
      rsp_q      <= rdRsp;
    end else if (rsp_ready_i) begin
      rspValid_q <= 1'b0;
    end
  end

  assign rsp_valid_o = rspValid_q;
  assign rsp_data_o  = rsp_q.data[XLEN-1:0];
  assign rsp_error_o = rsp_q.error;
  assign wr_error_o  = wrError_q;

  if (XLEN < CSR_DATA_MAX) begin : g_unused
    logic unusedRspBits;
    assign unusedRspBits = ^rsp_q.data[CSR_DATA_MAX-1:XLEN];
  end

  always_comb begin
    for (int p = 0; p < NUM_FPU_PORTS; p++) begin
      fpu_read_frm_o[p] = fcsr_q[fpu_read_wid_i[p]][FCSR_BITS-1:FFLAGS_BITS];
    end
  end

  for (genvar i = 0; i < NUM_CTRS; i++) begin : g_ctr
    vx_csr_ctr #(
      .XLEN     (XLEN),
      .CTR_BITS (CTR_BITS),
      .INC_BITS (INC_BITS)
    ) u_ctr (
      .clk       (clk),
      .reset     (reset),
      .en_i      (ctrEn_q[i]),
      .inc_i     (ctr_inc_i[i]),
      .wr_lo_i   (wrCtrLo[i]),
      .wr_hi_i   (wrCtrHi[i]),
      .wr_data_i (wr_data_i),
      .count_o   (ctrVal[i])
    );
  end

endmodule
